sysid_check_ctrl: RTL

//  Avalon-MM read master that sequences the system-ID slave: reads word 0 (ID), then word 1 (timestamp).

---
 rtl/sysid_check_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sysid_check_ctrl.sv
// rtl/sysid_check_ctrl.sv - Avalon-MM read master that checks the system-ID slave (ID, then timestamp)
module sysid_check_ctrl #(
    parameter logic [31:0] EXP_ID      = 32'hACD51302,
    parameter logic [31:0] EXP_TS      = 32'h55878928,
    parameter int          TIMEOUT_CYC = 255,
    parameter int          RECHECK_CYC = 0,
    parameter int          AUTO_START  = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_ID = 3'd1,
        S_WT_ID = 3'd2,
        S_RD_TS = 3'd3,
        S_WT_TS = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [31:0] RC_LAST = (RECHECK_CYC > 0) ? 32'(RECHECK_CYC - 1) : 32'd0;

    state_t      state_q, state_d;
    logic        init_q, pend_q, pend_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [31:0] rcnt_q, rcnt_d;
    logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, to_err_q, to_err_d;
    logic [31:0] id_val_q, id_val_d, ts_val_q, ts_val_d;

    logic is_rd, is_wt, is_ts, got, tmo, recheck_hit;

    assign is_rd       = (state_q == S_RD_ID) || (state_q == S_RD_TS);
    assign is_wt       = (state_q == S_WT_ID) || (state_q == S_WT_TS);
    assign is_ts       = (state_q == S_RD_TS) || (state_q == S_WT_TS);
    // a zero-latency slave hands back data in the very cycle it accepts the request
    assign got         = (is_rd && !avm_waitrequest && avm_readdatavalid) || (is_wt && avm_readdatavalid);
    assign tmo         = (is_rd || is_wt) && (tcnt_q >= TO_LAST);
    assign recheck_hit = (RECHECK_CYC != 0) && (rcnt_q == RC_LAST);

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        tcnt_d   = tcnt_q;
        rcnt_d   = rcnt_q;
        id_ok_d  = id_ok_q;
        ts_ok_d  = ts_ok_q;
        to_err_d = to_err_q;
        id_val_d = id_val_q;
        ts_val_d = ts_val_q;
        case (state_q)
            S_IDLE: begin
                if (RECHECK_CYC != 0) rcnt_d = rcnt_q + 32'd1;
                if (start || pend_q || recheck_hit) begin
                    state_d  = S_RD_ID;
                    pend_d   = 1'b0;
                    rcnt_d   = '0;
                    tcnt_d   = '0;
                    id_ok_d  = 1'b0;
                    ts_ok_d  = 1'b0;
                    to_err_d = 1'b0;
                end
            end
            S_RD_ID, S_WT_ID, S_RD_TS, S_WT_TS: begin
                tcnt_d = tcnt_q + 16'd1;
                if (got) begin
                    if (is_ts) begin
                        ts_val_d = avm_readdata;
                        ts_ok_d  = (avm_readdata == EXP_TS);
                        state_d  = S_FIN;
                    end else begin
                        id_val_d = avm_readdata;
                        id_ok_d  = (avm_readdata == EXP_ID);
                        tcnt_d   = '0;
                        state_d  = S_RD_TS;
                    end
                end else if (tmo) begin
                    to_err_d = 1'b1;
                    state_d  = S_FIN;
                end else if (is_rd && !avm_waitrequest) begin
                    state_d = is_ts ? S_WT_TS : S_WT_ID;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                rcnt_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase
        if (!init_q && (AUTO_START != 0) && (state_d == S_IDLE)) pend_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            init_q   <= 1'b0;
            pend_q   <= 1'b0;
            tcnt_q   <= '0;
            rcnt_q   <= '0;
            id_ok_q  <= 1'b0;
            ts_ok_q  <= 1'b0;
            to_err_q <= 1'b0;
            id_val_q <= '0;
            ts_val_q <= '0;
        end else begin
            state_q  <= state_d;
            init_q   <= 1'b1;
            pend_q   <= pend_d;
            tcnt_q   <= tcnt_d;
            rcnt_q   <= rcnt_d;
            id_ok_q  <= id_ok_d;
            ts_ok_q  <= ts_ok_d;
            to_err_q <= to_err_d;
            id_val_q <= id_val_d;
            ts_val_q <= ts_val_d;
        end
    end

    assign avm_read    = is_rd;
    assign avm_address = (state_q == S_RD_TS);
    assign busy        = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done        = (state_q == S_FIN);
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout_err = to_err_q;
    assign id_value    = id_val_q;
    assign ts_value    = ts_val_q;

endmodule
